// File: rtl/int_sequencer.sv
// Interrupt / reset entry sequencer.
// Steps the CPU through the stack pushes and vector fetch for RESET, NMI, BRK and IRQ.
// A sequence starts only at an instruction boundary.
// Ports:
//   i_clk, i_rst             clock; asynchronous active-high reset
//   i_nmi_n                  NMI, falling-edge sensitive
//   i_irq_n                  IRQ, active-low level
//   i_brk_req                BRK opcode decoded
//   i_i_flag                 status interrupt-disable bit
//   i_instr_done             instruction boundary strobe
//   o_busy                   high in every state except idle
//   o_push_pch/pcl/p         stack push strobes
//   o_b_bit                  B flag value for the pushed status
//   o_load_vec_lo/hi         PC byte loads from the vector fetch
//   o_vec_addr               vector byte address (0 outside the fetch states)
//   o_set_i                  set interrupt-disable flag
//   o_ack, o_ack_src         completion pulse and source of the last completed sequence
module int_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_brk_req,
  input  logic        i_i_flag,
  input  logic        i_instr_done,
  output logic        o_busy,
  output logic        o_push_pch,
  output logic        o_push_pcl,
  output logic        o_push_p,
  output logic        o_b_bit,
  output logic        o_load_vec_lo,
  output logic        o_load_vec_hi,
  output logic [15:0] o_vec_addr,
  output logic        o_set_i,
  output logic        o_ack,
  output logic [1:0]  o_ack_src
);

  typedef enum logic [2:0] {
    StRstHold, StIdle, StPushPch, StPushPcl, StPushP, StFetchLo, StFetchHi, StDone
  } state_e;

  localparam logic [1:0] SrcReset = 2'd0;
  localparam logic [1:0] SrcNmi   = 2'd1;
  localparam logic [1:0] SrcBrk   = 2'd2;
  localparam logic [1:0] SrcIrq   = 2'd3;

  state_e     r_state, w_state_d;
  logic [1:0] r_src, w_src_d;
  logic [1:0] r_ack_src, w_ack_src_d;
  logic       r_nmi_prev;
  logic       r_nmi_pend, w_nmi_pend_d;
  logic       w_nmi_edge;
  logic [15:0] w_vec_base;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StRstHold;
      r_src      <= SrcReset;
      r_ack_src  <= SrcReset;
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_src      <= w_src_d;
      r_ack_src  <= w_ack_src_d;
      r_nmi_prev <= i_nmi_n;
      r_nmi_pend <= w_nmi_pend_d;
    end
  end

  assign w_nmi_edge = r_nmi_prev & ~i_nmi_n;

  always_comb begin
    w_state_d   = r_state;
    w_src_d     = r_src;
    w_ack_src_d = r_ack_src;
    unique case (r_state)
      StRstHold: begin
        // Reset skips the pushes and goes straight to the vector fetch.
        w_state_d = StFetchLo;
        w_src_d   = SrcReset;
      end
      StIdle: begin
        if (i_instr_done) begin
          if (r_nmi_pend) begin
            w_state_d = StPushPch;
            w_src_d   = SrcNmi;
          end else if (i_brk_req) begin
            w_state_d = StPushPch;
            w_src_d   = SrcBrk;
          end else if (!i_irq_n && !i_i_flag) begin
            w_state_d = StPushPch;
            w_src_d   = SrcIrq;
          end
        end
      end
      StPushPch: w_state_d = StPushPcl;
      StPushPcl: w_state_d = StPushP;
      StPushP: begin
        w_state_d = StFetchLo;
        // A pending NMI hijacks an IRQ/BRK sequence at the vector fetch.
        if (r_nmi_pend && (r_src == SrcBrk || r_src == SrcIrq)) w_src_d = SrcNmi;
      end
      StFetchLo: w_state_d = StFetchHi;
      StFetchHi: begin
        w_state_d   = StDone;
        w_ack_src_d = r_src;
      end
      StDone:    w_state_d = StIdle;
      default:   w_state_d = StRstHold;
    endcase
  end

  // Pending NMI is consumed when the fetch of the NMI vector begins; a fresh edge in
  // that same cycle keeps it set.
  always_comb begin
    w_nmi_pend_d = w_nmi_edge |
                   (r_nmi_pend & ~(r_state == StPushP && w_src_d == SrcNmi));
  end

  always_comb begin
    w_vec_base = 16'hFFFE;
    unique case (r_src)
      SrcReset: w_vec_base = 16'hFFFC;
      SrcNmi:   w_vec_base = 16'hFFFA;
      default:  w_vec_base = 16'hFFFE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != StIdle);
    o_push_pch    = (r_state == StPushPch);
    o_push_pcl    = (r_state == StPushPcl);
    o_push_p      = (r_state == StPushP);
    o_b_bit       = (r_state == StPushP) && (r_src == SrcBrk);
    o_load_vec_lo = (r_state == StFetchLo);
    o_load_vec_hi = (r_state == StFetchHi);
    o_set_i       = (r_state == StFetchLo);
    o_ack         = (r_state == StDone);
    o_ack_src     = r_ack_src;
    o_vec_addr    = 16'h0000;
    if (r_state == StFetchLo) o_vec_addr = w_vec_base;
    if (r_state == StFetchHi) o_vec_addr = w_vec_base + 16'd1;
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer.
// Expected output vectors are queued when stimulus is applied and popped one per clock.
module tb_int_sequencer;

  logic        clk;
  logic        rst;
  logic        nmi_n, irq_n, brk_req, i_flag, instr_done;
  logic        busy, push_pch, push_pcl, push_p, b_bit, load_lo, load_hi, set_i, ack;
  logic [15:0] vec_addr;
  logic [1:0]  ack_src;

  int_sequencer u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_nmi_n       (nmi_n),
    .i_irq_n       (irq_n),
    .i_brk_req     (brk_req),
    .i_i_flag      (i_flag),
    .i_instr_done  (instr_done),
    .o_busy        (busy),
    .o_push_pch    (push_pch),
    .o_push_pcl    (push_pcl),
    .o_push_p      (push_p),
    .o_b_bit       (b_bit),
    .o_load_vec_lo (load_lo),
    .o_load_vec_hi (load_hi),
    .o_vec_addr    (vec_addr),
    .o_set_i       (set_i),
    .o_ack         (ack),
    .o_ack_src     (ack_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, pch, pcl, p, b, lo, hi, set_i, ack, ack_src[1:0], vec_addr[15:0]}
  logic [26:0] obs;
  assign obs = {busy, push_pch, push_pcl, push_p, b_bit, load_lo, load_hi, set_i, ack,
                ack_src, vec_addr};

  localparam int KRst  = 0;
  localparam int KIdle = 1;
  localparam int KPch  = 2;
  localparam int KPcl  = 3;
  localparam int KP    = 4;
  localparam int KFlo  = 5;
  localparam int KFhi  = 6;
  localparam int KDone = 7;

  logic [26:0] exp_q[$];
  logic [1:0]  held;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [15:0] vbase(input logic [1:0] s);
    if (s == 2'd0) return 16'hFFFC;
    if (s == 2'd1) return 16'hFFFA;
    return 16'hFFFE;
  endfunction

  function automatic logic [26:0] ev(input int k, input logic [1:0] s, input logic [1:0] h);
    logic [26:0] v;
    v = 27'd0;
    case (k)
      KRst:  v = {9'b1_0000_0000, 2'd0, 16'h0000};
      KIdle: v = {9'b0_0000_0000, h, 16'h0000};
      KPch:  v = {9'b1_1000_0000, h, 16'h0000};
      KPcl:  v = {9'b1_0100_0000, h, 16'h0000};
      KP:    v = {4'b1_001, (s == 2'd2), 4'b0000, h, 16'h0000};
      KFlo:  v = {9'b1_0000_1010, h, vbase(s)};
      KFhi:  v = {9'b1_0000_0100, h, vbase(s) + 16'd1};
      KDone: v = {9'b1_0000_0001, s, 16'h0000};
      default: v = 27'd0;
    endcase
    return v;
  endfunction

  task automatic pushk(input int k, input logic [1:0] s);
    if (k == KRst) held = 2'd0;
    if (k == KDone) held = s;
    exp_q.push_back(ev(k, s, held));
  endtask

  // Full pushed sequence; s0 is the accepted source, sf the source at the vector fetch.
  task automatic push_seq(input logic [1:0] s0, input logic [1:0] sf);
    pushk(KPch, s0);
    pushk(KPcl, s0);
    pushk(KP, s0);
    pushk(KFlo, sf);
    pushk(KFhi, sf);
    pushk(KDone, sf);
    pushk(KIdle, sf);
  endtask

  task automatic push_rst_seq();
    pushk(KFlo, 2'd0);
    pushk(KFhi, 2'd0);
    pushk(KDone, 2'd0);
    pushk(KIdle, 2'd0);
  endtask

  task automatic cmp(input string tag, input logic [26:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      cmp(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    held       = 2'd0;
    rst        = 1'b1;
    nmi_n      = 1'b1;
    irq_n      = 1'b1;
    brk_req    = 1'b0;
    i_flag     = 1'b1;
    instr_done = 1'b0;

    // Reset hold
    #2;
    cmp("reset_hold", ev(KRst, 2'd0, 2'd0));
    pushk(KRst, 2'd0);
    step("reset_hold_clk");
    rst = 1'b0;
    push_rst_seq();
    step("rst_fetch_lo");
    step("rst_fetch_hi");
    step("rst_done");
    step("rst_idle");

    // IRQ accepted, then deasserted mid-sequence
    irq_n = 1'b0; i_flag = 1'b0; instr_done = 1'b1;
    push_seq(2'd3, 2'd3);
    step("irq_pch");
    instr_done = 1'b0; irq_n = 1'b1;
    step("irq_pcl");
    step("irq_p");
    step("irq_fetch_lo");
    step("irq_fetch_hi");
    step("irq_done");
    step("irq_idle");

    // IRQ masked
    irq_n = 1'b0; i_flag = 1'b1; instr_done = 1'b1;
    pushk(KIdle, 2'd0);
    step("irq_masked");
    instr_done = 1'b0;
    pushk(KIdle, 2'd0);
    step("irq_masked2");

    // BRK with I set
    brk_req = 1'b1; instr_done = 1'b1;
    push_seq(2'd2, 2'd2);
    step("brk_pch");
    brk_req = 1'b0; instr_done = 1'b0;
    for (int i = 0; i < 6; i++) step("brk_seq");

    // BRK and IRQ coincident: BRK first, IRQ at the next boundary
    i_flag = 1'b0; brk_req = 1'b1; instr_done = 1'b1;
    push_seq(2'd2, 2'd2);
    step("coinc_brk_pch");
    brk_req = 1'b0; instr_done = 1'b0;
    for (int i = 0; i < 6; i++) step("coinc_brk_seq");
    instr_done = 1'b1;
    push_seq(2'd3, 2'd3);
    step("coinc_irq_pch");
    instr_done = 1'b0; irq_n = 1'b1;
    for (int i = 0; i < 6; i++) step("coinc_irq_seq");

    // NMI hijacks an IRQ sequence
    irq_n = 1'b0; instr_done = 1'b1;
    push_seq(2'd3, 2'd1);
    step("hij_pch");
    instr_done = 1'b0; irq_n = 1'b1;
    step("hij_pcl");
    nmi_n = 1'b0;
    step("hij_p");
    step("hij_fetch_lo");
    step("hij_fetch_hi");
    step("hij_done");
    step("hij_idle");
    // NMI held low: no second NMI
    instr_done = 1'b1;
    pushk(KIdle, 2'd0);
    step("nmi_no_retrigger");
    instr_done = 1'b0;
    pushk(KIdle, 2'd0);
    step("nmi_no_retrigger2");

    // NMI pending while no boundary arrives
    nmi_n = 1'b1;
    pushk(KIdle, 2'd0);
    step("nmi_rearm");
    nmi_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pushk(KIdle, 2'd0);
      step("nmi_wait_boundary");
    end
    instr_done = 1'b1;
    push_seq(2'd1, 2'd1);
    step("nmi_pch");
    instr_done = 1'b0;
    for (int i = 0; i < 6; i++) step("nmi_seq");

    // Reset mid-sequence with an NMI pending
    nmi_n = 1'b1;
    pushk(KIdle, 2'd0);
    step("pre_abort_idle");
    irq_n = 1'b0; instr_done = 1'b1;
    pushk(KPch, 2'd3);
    pushk(KPcl, 2'd3);
    step("abort_pch");
    instr_done = 1'b0; irq_n = 1'b1; nmi_n = 1'b0;
    step("abort_pcl");
    rst = 1'b1;
    #1;
    cmp("abort_async", ev(KRst, 2'd0, 2'd0));
    held = 2'd0;
    nmi_n = 1'b1;
    pushk(KRst, 2'd0);
    step("abort_hold");
    rst = 1'b0;
    push_rst_seq();
    for (int i = 0; i < 4; i++) step("abort_rst_seq");
    instr_done = 1'b1;
    pushk(KIdle, 2'd0);
    step("abort_pend_cleared");
    instr_done = 1'b0;
    pushk(KIdle, 2'd0);
    step("abort_pend_cleared2");

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
